// File: rtl/gpio_btn_pkg.sv
// Shared types and default timing constants for the GPIO button bank.
package gpio_btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    // 10 ms debounce and 1 s long-press at 50 MHz
    localparam int unsigned DEB_CYCLES_50M  = 500000;
    localparam int unsigned LONG_CYCLES_50M = 50000000;

endpackage

// File: rtl/gpio_btn_channel.sv
// Single button channel: 2-FF synchroniser, debounce FSM, press/release
// pulses, clearable toggle latch. Optional long-press detector enabled by
// defining GPIO_LONG_PRESS_EN; otherwise o_long is tied low.
module gpio_btn_channel
    import gpio_btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_50M,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_50M
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_gpio,
    input  logic i_clear,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_toggle,
    output logic o_long
);

    localparam int unsigned    CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  DEB_TERM = CW'(DEB_CYCLES);
    localparam logic           IDLE_LVL = ACTIVE_LOW;

    logic          sync1, sync2;
    logic          pr;
    btn_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          press_evt, release_evt;

    // Two-stage synchroniser, preset to the released pin level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= i_gpio;
            sync2 <= sync1;
        end
    end

    assign pr = sync2 ^ IDLE_LVL;

    // Debounce state and counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Debounce next-state logic; counter stops at DEB_TERM and never wraps
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state)
            IDLE: begin
                if (pr) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pr) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DEB_TERM) begin
                    state_nx  = HELD;
                    press_evt = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!pr) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pr) begin
                    state_nx = HELD;
                end else if (cnt == DEB_TERM) begin
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    release_evt = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Registered level, event pulses and toggle; clear beats a press toggle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_toggle  <= 1'b0;
        end else begin
            o_press   <= press_evt;
            o_release <= release_evt;
            if (press_evt)
                o_level <= 1'b1;
            else if (release_evt)
                o_level <= 1'b0;
            if (i_clear)
                o_toggle <= 1'b0;
            else if (press_evt)
                o_toggle <= ~o_toggle;
        end
    end

`ifdef GPIO_LONG_PRESS_EN
    localparam int unsigned    LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0]  LONG_TERM = LW'(LONG_CYCLES);
    localparam logic [LW-1:0]  LONG_PRE  = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] hold_cnt;

    // Hold timer keeps running through release bounce; the pulse fires on
    // the step into LONG_TERM, so saturation gives at most one per press
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt <= '0;
            o_long   <= 1'b0;
        end else begin
            o_long <= 1'b0;
            if (press_evt || state_nx == IDLE) begin
                hold_cnt <= '0;
            end else if ((state == HELD || state == RELEASE_WAIT) &&
                         hold_cnt != LONG_TERM) begin
                hold_cnt <= hold_cnt + LW'(1);
                o_long   <= (hold_cnt == LONG_PRE);
            end
        end
    end
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/gpio_button_bank.sv
// N_CH independent debounced buttons with press/release pulses and toggle
// latches. Long-press pulses available when GPIO_LONG_PRESS_EN is defined.
module gpio_button_bank
    import gpio_btn_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_50M,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_50M
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_gpio,
    input  logic [N_CH-1:0] i_clear,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_toggle,
    output logic [N_CH-1:0] o_long
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        gpio_btn_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_gpio   (i_gpio[k]),
            .i_clear  (i_clear[k]),
            .o_level  (o_level[k]),
            .o_press  (o_press[k]),
            .o_release(o_release[k]),
            .o_toggle (o_toggle[k]),
            .o_long   (o_long[k])
        );
    end

endmodule

// File: tb/tb_gpio_button_bank.sv
// Directed bench for gpio_button_bank (N_CH=4, DEB_CYCLES=4, LONG_CYCLES=10,
// active-low pins). Long-press expectations follow GPIO_LONG_PRESS_EN.
module tb_gpio_button_bank;

    logic       clk;
    logic       rst;
    logic [3:0] gpio;
    logic [3:0] clr;
    logic [3:0] level, press, release_p, toggle, long_p;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] seen_press   = '0;
    logic [3:0] seen_release = '0;
    int         long_pulses  = 0;
    int         overlap      = 0;
    logic [3:0] hit_vec;

    gpio_button_bank #(
        .N_CH       (4),
        .DEB_CYCLES (4),
        .ACTIVE_LOW (1'b1),
        .LONG_CYCLES(10)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_gpio   (gpio),
        .i_clear  (clr),
        .o_level  (level),
        .o_press  (press),
        .o_release(release_p),
        .o_toggle (toggle),
        .o_long   (long_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event monitor, sampled away from the active edge
    always @(negedge clk) begin
        seen_press   = seen_press | press;
        seen_release = seen_release | release_p;
        if (long_p[0]) long_pulses++;
        if ((press & release_p) != 4'b0000) overlap++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [3:0] pick(input int sel);
        case (sel)
            0:       return press;
            1:       return release_p;
            default: return long_p;
        endcase
    endfunction

    // Latency counted in edges after the first edge that samples the new pin
    // state; then confirms the pulse is one cycle wide.
    task automatic wait_pulse(input string tag, input int sel, input int ch, input int exp_lat);
        int  edges = 0;
        bit  hit   = 1'b0;
        while (!hit && edges < 40) begin
            step();
            edges++;
            hit = pick(sel)[ch];
        end
        hit_vec = pick(sel);
        check({tag, "_lat"}, edges - 1, exp_lat);
        step();
        check({tag, "_width"}, {31'd0, pick(sel)[ch]}, 0);
    endtask

    initial begin
        int k;
        rst  = 1'b1;
        gpio = 4'hF;
        clr  = 4'h0;
        steps(3);
        check("rst_outputs", {level, press, release_p, toggle, long_p}, 0);
        rst = 1'b0;
        steps(3);
        check("idle_outputs", {level, press, release_p, toggle}, 0);

        // 1. Clean press on ch0
        seen_press = '0;
        gpio[0] = 1'b0;
        wait_pulse("press0", 0, 0, 6);
        check("press0_level", level, 4'b0001);
        check("press0_toggle", toggle, 4'b0001);
        check("press0_only_ch0", seen_press, 4'b0001);
        steps(3);
        check("press0_level_hold", level, 4'b0001);

        // 2. Bounce on ch2: 3-cycle glitch, then 1/1 chatter
        seen_press   = '0;
        seen_release = '0;
        gpio[2] = 1'b0;
        steps(3);
        gpio[2] = 1'b1;
        steps(4);
        for (int i = 0; i < 10; i++) begin
            gpio[2] = (i % 2 == 1);
            step();
        end
        gpio[2] = 1'b1;
        steps(8);
        check("bounce_no_press", seen_press, 4'b0000);
        check("bounce_no_release", seen_release, 4'b0000);
        check("bounce_level", level, 4'b0001);

        // 3. Release ch0, then second press flips the toggle back
        gpio[0] = 1'b1;
        wait_pulse("release0", 1, 0, 6);
        check("release0_level", level, 4'b0000);
        check("release0_toggle", toggle, 4'b0001);
        steps(2);
        gpio[0] = 1'b0;
        wait_pulse("press0b", 0, 0, 6);
        check("press0b_toggle", toggle, 4'b0000);
        gpio[0] = 1'b1;
        steps(12);
        check("release0b_level", level, 4'b0000);

        // 4. Clear coincident with press acceptance on ch1, then clear alone
        gpio[1] = 1'b0;
        steps(6);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        check("clr_coinc_press", press, 4'b0010);
        check("clr_coinc_toggle", toggle, 4'b0000);
        check("clr_coinc_level", level, 4'b0010);
        gpio[1] = 1'b1;
        steps(12);
        gpio[1] = 1'b0;
        wait_pulse("press1", 0, 1, 6);
        check("press1_toggle", toggle, 4'b0010);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        check("clr_alone_toggle", toggle, 4'b0000);
        gpio[1] = 1'b1;
        steps(12);

        // 5. Reset while ch3 is mid-debounce and ch2 is held
        gpio[2] = 1'b0;
        wait_pulse("press2", 0, 2, 6);
        gpio[3] = 1'b0;
        steps(4);
        check("pre_rst_level", level, 4'b0100);
        check("pre_rst_toggle", toggle, 4'b0100);
        rst = 1'b1;
        step();
        check("mid_rst_outputs", {level, press, release_p, toggle, long_p}, 0);
        steps(2);
        check("mid_rst_outputs2", {level, press, release_p, toggle, long_p}, 0);
        rst = 1'b0;
        wait_pulse("press3_after_rst", 0, 3, 6);
        check("after_rst_simul", hit_vec, 4'b1100);
        check("after_rst_toggle", toggle, 4'b1100);
        gpio = 4'hF;
        steps(12);
        check("after_rst_release", level, 4'b0000);

        // 6. Long press on ch0
        long_pulses = 0;
        gpio[0] = 1'b0;
        wait_pulse("press0c", 0, 0, 6);
        k = 1;
        while (!long_p[0] && k < 40) begin
            step();
            k++;
        end
`ifdef GPIO_LONG_PRESS_EN
        check("long0_lat", k, 10);
        steps(15);
        check("long0_once", long_pulses, 1);
`else
        check("long0_absent", long_pulses, 0);
        check("long0_vec", long_p, 4'b0000);
`endif
        gpio[0] = 1'b1;
        steps(12);

        check("press_release_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
